// File: rtl/spi_ram_arbiter_if.sv
// Memory-port bundle shared by the CPU-style masters and the SPI RAM controller.
// The master modport drives strobes; the slave side answers with data and busy.
interface spi_ram_arbiter_if #(
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              rd;
   logic              wr;
   logic [31:0]       rdata;
   logic              rbusy;
   logic              wbusy;

   modport master (
      output addr, wdata, rd, wr,
      input  rdata, rbusy, wbusy
   );

   modport slave (
      input  addr, wdata, rd, wr,
      output rdata, rbusy, wbusy
   );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Two-master arbiter in front of the word-addressed SPI RAM controller.
// Requests are latched per master and served one at a time (RR or fixed).
module spi_ram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   spi_ram_arbiter_if.slave  m0,
   spi_ram_arbiter_if.slave  m1,
   spi_ram_arbiter_if.master s,
   output logic              grant
);
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   state_t state;

   logic [1:0]              pend_rd;
   logic [1:0]              pend_wr;
   logic [1:0]              pend;
   logic [1:0]              cap_rd;
   logic [1:0]              cap_wr;
   logic [1:0]              in_rd;
   logic [1:0]              in_wr;
   logic [1:0][ADDR_W-1:0]  in_addr;
   logic [1:0][ADDR_W-1:0]  lat_addr;
   logic [1:0][31:0]        in_wdata;
   logic [1:0][31:0]        lat_wdata;
   logic [1:0][31:0]        rdata;
   logic                    prefer;
   logic                    cur_wr;
   logic                    win;
   logic                    done;
   logic [ADDR_W-1:0]       s_addr;
   logic [31:0]             s_wdata;
   logic                    s_rd;
   logic                    s_wr;

   assign in_rd    = {m1.rd, m0.rd};
   assign in_wr    = {m1.wr, m0.wr};
   assign in_addr  = {m1.addr, m0.addr};
   assign in_wdata = {m1.wdata, m0.wdata};

   // A write strobe wins over a simultaneous read strobe.
   assign pend   = pend_rd | pend_wr;
   assign cap_wr = ~pend & in_wr;
   assign cap_rd = ~pend & in_rd & ~in_wr;

   always_comb begin
      win = pend[1];
      if (pend[0] && pend[1]) begin
         win = FIXED_PRIO ? 1'b0 : prefer;
      end
   end

   assign done = (state == WAIT) && !(cur_wr ? s.wbusy : s.rbusy);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pend_rd   <= '0;
         pend_wr   <= '0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         rdata     <= '0;
         prefer    <= 1'b0;
         cur_wr    <= 1'b0;
         grant     <= 1'b0;
         s_addr    <= '0;
         s_wdata   <= '0;
         s_rd      <= 1'b0;
         s_wr      <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (cap_rd[i] || cap_wr[i]) begin
               lat_addr[i] <= in_addr[i];
            end
            if (cap_wr[i]) begin
               lat_wdata[i] <= in_wdata[i];
            end
         end
         pend_rd <= pend_rd | cap_rd;
         pend_wr <= pend_wr | cap_wr;

         unique case (state)
            IDLE: begin
               if (|pend) begin
                  grant   <= win;
                  cur_wr  <= pend_wr[win];
                  s_addr  <= lat_addr[win];
                  s_wdata <= lat_wdata[win];
                  s_rd    <= pend_rd[win];
                  s_wr    <= pend_wr[win];
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               s_rd  <= 1'b0;
               s_wr  <= 1'b0;
               state <= WAIT;
            end
            WAIT: begin
               // The served master cannot capture this cycle, so the
               // bit clear below never collides with a new capture.
               if (done) begin
                  if (!cur_wr) begin
                     rdata[grant] <= s.rdata;
                  end
                  pend_rd[grant] <= 1'b0;
                  pend_wr[grant] <= 1'b0;
                  prefer         <= ~grant;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m0.rdata = rdata[0];
   assign m0.rbusy = pend_rd[0];
   assign m0.wbusy = pend_wr[0];
   assign m1.rdata = rdata[1];
   assign m1.rbusy = pend_rd[1];
   assign m1.wbusy = pend_wr[1];

   assign s.addr  = s_addr;
   assign s.wdata = s_wdata;
   assign s.rd    = s_rd;
   assign s.wr    = s_wr;
endmodule
